pp_ram_stream_writer: RTL and testbench

PP_RAM_STREAM_WRITER -- requirements
Module: pp_ram_stream_writer

---
 rtl/pp_ram_stream_writer.sv | 192 +++++++++++++++++++
 tb/tb_pp_ram_stream_writer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pp_ram_stream_writer.sv
// pp_ram_stream_writer
// Turns a valid/ready word stream into write strobes for one half of a
// ping-pong RAM. Each buffer holds NUM_WORDS words. The buffer commits
// (wr_done_o) when it fills up or when the frame ends early. After a commit
// the block waits one settle cycle so the controller's full flag can catch up.
//
// Optional feature: define PP_WRITER_PAD_EN to pad an early-ended buffer
// with PAD_VALUE up to NUM_WORDS-1 before committing it. Without the macro,
// an early-ended buffer commits partially filled and the PAD state does not
// exist.
module pp_ram_stream_writer #(
    parameter int                    ADDR_WIDTH = 7,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_WORDS  = 68,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  s_valid_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_last_i,
    output logic                  s_ready_o,
    input  logic                  pp_ram_full_i,
    output logic [ADDR_WIDTH-1:0] waddr_o,
    output logic                  wr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  wr_done_o,
    output logic [ADDR_WIDTH:0]   last_len_o,
    output logic [15:0]           frame_cnt_o
);

    // Index of the final word slot in a buffer.
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = (ADDR_WIDTH+1)'(1);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_SETTLE = 2'd2
`ifdef PP_WRITER_PAD_EN
        ,
        ST_PAD    = 2'd3
`endif
    } state_t;

    state_t                state_q, state_d;

    // Write pointer within the current buffer. In PAD it walks the pad slots.
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    // Number of stream words placed in the current buffer (pad excluded).
    logic [ADDR_WIDTH:0]   len_q, len_d;

    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH:0]   last_len_q, last_len_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;

    logic                  ready_c;
    logic                  done_c;
    logic                  accept;
    logic                  at_last_idx;

    assign accept      = s_valid_i && ready_c;
    assign at_last_idx = (idx_q == LAST_IDX);

    // State register; reset discards any partial buffer without a commit.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    if (at_last_idx) begin
                        state_d = ST_COMMIT;
                    end else if (s_last_i) begin
`ifdef PP_WRITER_PAD_EN
                        state_d = ST_PAD;
`else
                        state_d = ST_COMMIT;
`endif
                    end
                end
            end
`ifdef PP_WRITER_PAD_EN
            ST_PAD: begin
                // The final pad slot is issued here; its write lands in COMMIT.
                if (at_last_idx) begin
                    state_d = ST_COMMIT;
                end
            end
`endif
            ST_COMMIT: state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_FILL;
            default:   state_d = ST_FILL;
        endcase
    end

    // FSM outputs: ready only while filling and the buffer is free; commit pulse.
    always_comb begin
        ready_c = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            ST_FILL:   ready_c = !pp_ram_full_i;
            ST_COMMIT: done_c  = 1'b1;
            default: begin
                ready_c = 1'b0;
                done_c  = 1'b0;
            end
        endcase
    end

    // Datapath next-state: registered write port, counters and commit stats.
    always_comb begin
        idx_d       = idx_q;
        len_d       = len_q;
        wr_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        last_len_d  = last_len_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    wr_d    = 1'b1;
                    waddr_d = idx_q;
                    wdata_d = s_data_i;
                    len_d   = {1'b0, idx_q} + LEN_ONE;
                    if (!at_last_idx) begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef PP_WRITER_PAD_EN
            ST_PAD: begin
                wr_d    = 1'b1;
                waddr_d = idx_q;
                wdata_d = PAD_VALUE;
                if (!at_last_idx) begin
                    idx_d = idx_q + 1'b1;
                end
            end
`endif
            ST_COMMIT: begin
                last_len_d  = len_q;
                frame_cnt_d = frame_cnt_q + 16'd1;
                idx_d       = '0;
            end
            default: begin
                idx_d = idx_q;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            idx_q       <= '0;
            len_q       <= '0;
            wr_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            last_len_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            idx_q       <= idx_d;
            len_q       <= len_d;
            wr_q        <= wr_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            last_len_q  <= last_len_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign s_ready_o   = ready_c;
    assign wr_done_o   = done_c;
    assign wr_o        = wr_q;
    assign waddr_o     = waddr_q;
    assign wdata_o     = wdata_q;
    assign last_len_o  = last_len_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_pp_ram_stream_writer.sv
// Testbench for pp_ram_stream_writer (default parameters). Expectations
// follow PP_WRITER_PAD_EN if the bench is compiled with it.
module tb_pp_ram_stream_writer;

    localparam int AW = 7;
    localparam int DW = 32;
    localparam int N  = 68;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          s_valid_i = 1'b0;
    logic [DW-1:0] s_data_i = '0;
    logic          s_last_i = 1'b0;
    logic          s_ready_o;
    logic          pp_ram_full_i = 1'b0;
    logic [AW-1:0] waddr_o;
    logic          wr_o;
    logic [DW-1:0] wdata_o;
    logic          wr_done_o;
    logic [AW:0]   last_len_o;
    logic [15:0]   frame_cnt_o;

    pp_ram_stream_writer dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .s_valid_i     (s_valid_i),
        .s_data_i      (s_data_i),
        .s_last_i      (s_last_i),
        .s_ready_o     (s_ready_o),
        .pp_ram_full_i (pp_ram_full_i),
        .waddr_o       (waddr_o),
        .wr_o          (wr_o),
        .wdata_o       (wdata_o),
        .wr_done_o     (wr_done_o),
        .last_len_o    (last_len_o),
        .frame_cnt_o   (frame_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] data;
        logic        done;
    } wr_exp_t;

    typedef struct {
        int len;
        int frame;
    } cm_exp_t;

    wr_exp_t wr_sb[$];
    cm_exp_t cm_sb[$];

    int checks   = 0;
    int failures = 0;
    int m_idx    = 0;
    int m_frame  = 0;
    int post_commit = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_wr(input int addr, input logic [31:0] data, input logic done);
        wr_exp_t e;
        e.addr = addr;
        e.data = data;
        e.done = done;
        wr_sb.push_back(e);
    endtask

    task automatic push_commit(input int len);
        cm_exp_t c;
        m_frame = (m_frame + 1) % 65536;
        c.len   = len;
        c.frame = m_frame;
        cm_sb.push_back(c);
        m_idx = 0;
    endtask

    // Expected effect of one accepted stream word.
    task automatic model_accept(input logic [31:0] d, input logic l);
        if (m_idx == N - 1) begin
            push_wr(m_idx, d, 1'b1);
            push_commit(N);
        end else if (l) begin
`ifdef PP_WRITER_PAD_EN
            push_wr(m_idx, d, 1'b0);
            for (int j = m_idx + 1; j < N; j++) begin
                push_wr(j, 32'd0, (j == N - 1));
            end
`else
            push_wr(m_idx, d, 1'b1);
`endif
            push_commit(m_idx + 1);
        end else begin
            push_wr(m_idx, d, 1'b0);
            m_idx++;
        end
    endtask

    // Present one word (called at posedge+1) and hold it until accepted.
    task automatic send(input logic [31:0] d, input logic l);
        bit acc = 0;
        s_valid_i = 1'b1;
        s_data_i  = d;
        s_last_i  = l;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            if (s_ready_o) begin
                model_accept(d, l);
                acc = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: word 0x%0h not accepted, required accept within 200 cycles", d);
        end
    endtask

    task automatic idle(input int n);
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every write, checks commit timing and stats.
    always @(negedge clk) begin
        int ph;
        wr_exp_t e;
        cm_exp_t c;
        if (!reset_i) begin
            ph = post_commit;
            post_commit = 0;
            if (ph == 2) begin
                chk("ready_after_settle", s_ready_o, !pp_ram_full_i);
            end
            if (ph == 1) begin
                chk("settle_ready", s_ready_o, 1'b0);
                chk("settle_no_wr", wr_o, 1'b0);
                if (cm_sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_commit: got last_len=%0d frame=%0d, required no commit", last_len_o, frame_cnt_o);
                end else begin
                    c = cm_sb.pop_front();
                    $display("COMMIT last_len=%0d frame_cnt=%0d", last_len_o, frame_cnt_o);
                    chk("last_len", last_len_o, c.len);
                    chk("frame_cnt", frame_cnt_o, c.frame);
                end
                post_commit = 2;
            end
            if (wr_o) begin
                if (wr_sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got addr=%0d data=0x%0h, required no write", waddr_o, wdata_o);
                end else begin
                    e = wr_sb.pop_front();
                    $display("WR addr=%0d data=0x%0h done=%0b", waddr_o, wdata_o, wr_done_o);
                    chk("waddr", waddr_o, e.addr);
                    chk("wdata", wdata_o, e.data);
                    chk("wr_done_align", wr_done_o, e.done);
                end
            end else if (wr_done_o) begin
                checks++;
                failures++;
                $display("FAIL done_without_write: got wr_done_o=1 wr_o=0, required wr_o=1");
            end
            if (wr_done_o) begin
                chk("commit_ready", s_ready_o, 1'b0);
                post_commit = 1;
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr", wr_o, 1'b0);
        chk("rst_waddr", waddr_o, 0);
        chk("rst_frame", frame_cnt_o, 0);
        reset_i = 1'b0;
        #1;
        chk("rst_ready", s_ready_o, 1'b1);
        chk("rst_done", wr_done_o, 1'b0);
        chk("rst_last_len", last_len_o, 0);
        chk("rst_wdata", wdata_o, 0);
        @(posedge clk);
        #1;

        // One full frame: words 0..67, last on 67
        for (int i = 0; i < N; i++) send(i, (i == N - 1));
        idle(3);

        // 150 words without last, then one closing word with last
        for (int i = 0; i < 150; i++) send(32'h1000 + i, 1'b0);
        send(32'h1000 + 150, 1'b1);
        idle(3);

        // Stall with full=1 for 10 cycles at idx 20
        for (int i = 0; i < 20; i++) send(32'h2000 + i, 1'b0);
        pp_ram_full_i = 1'b1;
        s_valid_i = 1'b1;
        s_data_i  = 32'h2000 + 20;
        s_last_i  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_ready", s_ready_o, 1'b0);
            if (i > 0) chk("stall_no_wr", wr_o, 1'b0);
            @(posedge clk);
            #1;
        end
        pp_ram_full_i = 1'b0;
        for (int i = 20; i < N; i++) send(32'h2000 + i, (i == N - 1));
        idle(3);

        // Early last on word 5
        for (int i = 0; i < 6; i++) send(32'h3000 + i, (i == 5));
        idle(4);

        // Reset pulse at idx 30
        for (int i = 0; i < 30; i++) send(32'h4000 + i, 1'b0);
        idle(2);
        reset_i = 1'b1;
        #1;
        chk("mid_rst_wr", wr_o, 1'b0);
        chk("mid_rst_waddr", waddr_o, 0);
        chk("mid_rst_wdata", wdata_o, 0);
        chk("mid_rst_done", wr_done_o, 1'b0);
        chk("mid_rst_frame", frame_cnt_o, 0);
        chk("mid_rst_last_len", last_len_o, 0);
        chk("mid_rst_ready", s_ready_o, 1'b1);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        m_idx   = 0;
        m_frame = 0;
        for (int i = 0; i < 3; i++) send(32'h5000 + i, (i == 2));
        idle(3);

        // Full raised in SETTLE after the second commit
        fork
            begin
                for (int i = 0; i < 3 * N; i++) send(32'h6000 + i, (i == 3 * N - 1));
            end
            begin
                int seen = 0;
                for (int t = 0; t < 2000 && seen < 2; t++) begin
                    @(negedge clk);
                    if (wr_done_o) seen++;
                end
                if (seen < 2) begin
                    checks++;
                    failures++;
                    $display("FAIL settle_watch_timeout: got %0d commits, required 2", seen);
                end else begin
                    @(posedge clk);
                    #1;
                    pp_ram_full_i = 1'b1;
                    repeat (5) @(posedge clk);
                    #1;
                    pp_ram_full_i = 1'b0;
                end
            end
        join
        idle(5);

        chk("sb_writes_drained", wr_sb.size(), 0);
        chk("sb_commits_drained", cm_sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
